// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl: two-core snooping bus arbiter with cache-to-cache transfer and block memory access
module snoop_bus_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  cctrans,
    input  logic [1:0]  ccwrite,
    input  logic [1:0]  dREN,
    input  logic [1:0]  dWEN,
    input  logic [31:0] daddr0,
    input  logic [31:0] daddr1,
    input  logic [31:0] dstore0,
    input  logic [31:0] dstore1,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic [1:0]  dwait,
    output logic [31:0] dload0,
    output logic [31:0] dload1,
    output logic [1:0]  ccwait,
    output logic [1:0]  ccinv,
    output logic [31:0] ccsnoopaddr0,
    output logic [31:0] ccsnoopaddr1,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore
);
    typedef enum logic [2:0] {IDLE, SNOOP, C2C, MEMRD, EVICT} state_t;
    state_t      state_q, state_d;
    logic        cnt_q, cnt_d, last_q, last_d, req_q, req_d, wr_q, wr_d, snp_q, snp_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  rq;
    logic        sel, oth, adv;
    logic [31:0] daddr_req, daddr_oth, dstore_req, dstore_oth;
    assign rq         = cctrans | dREN | dWEN;
    assign sel        = (&rq) ? ~last_q : rq[1];
    assign oth        = ~req_q;
    assign daddr_req  = req_q ? daddr1 : daddr0;
    assign daddr_oth  = req_q ? daddr0 : daddr1;
    assign dstore_req = req_q ? dstore1 : dstore0;
    assign dstore_oth = req_q ? dstore0 : dstore1;
    // State, word counter, round-robin pointer and latched transaction
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 1'b0;
            last_q  <= 1'b1;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            snp_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            snp_q   <= snp_d;
            addr_q  <= addr_d;
        end
    end
    // Arbitration, next state and bus outputs; the snoop signals stay up until IDLE is re-entered
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        req_d        = req_q;
        wr_d         = wr_q;
        snp_d        = snp_q;
        addr_d       = addr_q;
        adv          = 1'b0;
        dwait        = 2'b11;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ccwait       = 2'b00;
        ccinv        = 2'b00;
        dload0       = ramload;
        dload1       = ramload;
        ccsnoopaddr0 = '0;
        ccsnoopaddr1 = '0;
        ramaddr      = '0;
        ramstore     = '0;
        if (state_q != IDLE && snp_q) begin
            ccwait[oth]  = 1'b1;
            ccinv[oth]   = wr_q;
            ccsnoopaddr0 = oth ? '0 : addr_q;
            ccsnoopaddr1 = oth ? addr_q : '0;
        end
        case (state_q)
            IDLE: if (|rq) begin
                req_d   = sel;
                last_d  = sel;
                addr_d  = sel ? daddr1 : daddr0;
                wr_d    = ccwrite[sel];
                snp_d   = cctrans[sel];
                state_d = cctrans[sel] ? SNOOP : dWEN[sel] ? EVICT : MEMRD;
            end
            SNOOP: state_d = ccwrite[oth] ? C2C : MEMRD;
            C2C: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr_oth;
                ramstore = dstore_oth;
                dload0   = req_q ? ramload : dstore_oth;
                dload1   = req_q ? dstore_oth : ramload;
                dwait    = {2{~ramready}};
                adv      = ramready;
            end
            MEMRD: begin
                ramREN       = dREN[req_q];
                ramaddr      = daddr_req;
                dwait[req_q] = ~ramready;
                adv          = ramready & dREN[req_q];
            end
            EVICT: begin
                ramWEN       = dWEN[req_q];
                ramaddr      = daddr_req;
                ramstore     = dstore_req;
                dwait[req_q] = ~ramready;
                adv          = ramready & dWEN[req_q];
            end
            default: state_d = IDLE;
        endcase
        if (adv) begin
            cnt_d   = ~cnt_q;
            state_d = cnt_q ? IDLE : state_d;
        end
    end
endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// tb_snoop_bus_ctrl: directed scenarios plus randomized traffic checked against a transaction-level model
module tb_snoop_bus_ctrl;
    logic        CLK, RST, ramready, ramREN, ramWEN;
    logic [1:0]  cctrans, ccwrite, dREN, dWEN, dwait, ccwait, ccinv;
    logic [31:0] daddr0, daddr1, dstore0, dstore1, ramload;
    logic [31:0] dload0, dload1, ccsnoopaddr0, ccsnoopaddr1, ramaddr, ramstore;
    int checks = 0, failures = 0, comp = 0;
    bit started = 0;

    snoop_bus_ctrl dut (
        .CLK(CLK), .RST(RST), .cctrans(cctrans), .ccwrite(ccwrite), .dREN(dREN), .dWEN(dWEN),
        .daddr0(daddr0), .daddr1(daddr1), .dstore0(dstore0), .dstore1(dstore1),
        .ramload(ramload), .ramready(ramready), .dwait(dwait), .dload0(dload0), .dload1(dload1),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr0(ccsnoopaddr0), .ccsnoopaddr1(ccsnoopaddr1),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One outstanding bus transaction as seen from outside the controller
    typedef struct packed {
        logic        active;
        logic        req;
        logic [31:0] addr;
        logic        wr;
        logic        snooped;
        logic        snoop_cycle;
        logic        c2c;
        logic        write;
        logic [1:0]  words;
        logic        last;
    } model_t;

    typedef struct packed {
        logic [1:0]  dwait, ccwait, ccinv;
        logic        rren, rwen;
        logic [31:0] sa0, sa1, raddr, rstore, dl0, dl1;
    } exp_t;

    model_t m;

    function automatic model_t mreset();
        model_t n;
        n = '0;
        n.last = 1'b1;
        return n;
    endfunction

    function automatic model_t mstep(model_t s);
        model_t n;
        logic [1:0] r;
        logic en;
        n = s;
        r = cctrans | dREN | dWEN;
        if (!s.active) begin
            if (r != 2'b00) begin
                n.req         = (r == 2'b11) ? !s.last : (r == 2'b10);
                n.last        = n.req;
                n.active      = 1'b1;
                n.addr        = n.req ? daddr1 : daddr0;
                n.wr          = ccwrite[n.req];
                n.snooped     = cctrans[n.req];
                n.snoop_cycle = cctrans[n.req];
                n.c2c         = 1'b0;
                n.write       = !cctrans[n.req] && dWEN[n.req];
                n.words       = 2'd0;
            end
        end else if (s.snoop_cycle) begin
            n.snoop_cycle = 1'b0;
            n.c2c         = ccwrite[!s.req];
        end else begin
            en = s.c2c ? 1'b1 : s.write ? dWEN[s.req] : dREN[s.req];
            if (ramready && en) n.words = s.words + 2'd1;
            if (n.words == 2'd2) begin
                n.active = 1'b0;
                n.words  = 2'd0;
            end
        end
        return n;
    endfunction

    function automatic exp_t expect_out(model_t s);
        exp_t e;
        logic o;
        logic [31:0] ar, ao, so, sr;
        o  = !s.req;
        ar = s.req ? daddr1 : daddr0;
        ao = s.req ? daddr0 : daddr1;
        sr = s.req ? dstore1 : dstore0;
        so = s.req ? dstore0 : dstore1;
        e = '0;
        e.dwait = 2'b11;
        e.dl0 = ramload;
        e.dl1 = ramload;
        if (s.active && s.snooped) begin
            e.ccwait[o] = 1'b1;
            e.ccinv[o]  = s.wr;
            if (o) e.sa1 = s.addr; else e.sa0 = s.addr;
        end
        if (s.active && !s.snoop_cycle) begin
            if (s.c2c) begin
                e.rwen = 1'b1;
                e.raddr = ao;
                e.rstore = so;
                if (s.req) e.dl1 = so; else e.dl0 = so;
                e.dwait = ramready ? 2'b00 : 2'b11;
            end else if (s.write) begin
                e.rwen = dWEN[s.req];
                e.raddr = ar;
                e.rstore = sr;
                e.dwait[s.req] = !ramready;
            end else begin
                e.rren = dREN[s.req];
                e.raddr = ar;
                e.dwait[s.req] = !ramready;
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic neg();
        @(negedge CLK);
    endtask

    function automatic logic [1:0] rb(input int pct);
        return {($urandom_range(0, 99) < pct), ($urandom_range(0, 99) < pct)};
    endfunction

    // Reference model advances with the controller
    always @(posedge CLK or posedge RST)
        if (RST) m <= mreset();
        else m <= mstep(m);

    // Every-cycle comparison of all outputs against the model
    always @(negedge CLK) if (started) begin
        exp_t e;
        e = expect_out(m);
        chk("dwait", {30'd0, dwait}, {30'd0, e.dwait});
        chk("ccwait", {30'd0, ccwait}, {30'd0, e.ccwait});
        chk("ccinv", {30'd0, ccinv}, {30'd0, e.ccinv});
        chk("ramREN", {31'd0, ramREN}, {31'd0, e.rren});
        chk("ramWEN", {31'd0, ramWEN}, {31'd0, e.rwen});
        chk("ram_excl", {31'd0, ramREN & ramWEN}, 32'd0);
        chk("snoopaddr0", ccsnoopaddr0, e.sa0);
        chk("snoopaddr1", ccsnoopaddr1, e.sa1);
        chk("ramaddr", ramaddr, e.raddr);
        chk("ramstore", ramstore, e.rstore);
        chk("dload0", dload0, e.dl0);
        chk("dload1", dload1, e.dl1);
    end

    initial begin
        RST = 1'b1; cctrans = '0; ccwrite = '0; dREN = '0; dWEN = '0;
        daddr0 = '0; daddr1 = '0; dstore0 = '0; dstore1 = '0; ramload = 32'h5555_0000; ramready = 1'b0;
        @(posedge CLK);
        started = 1;
        neg();
        chk("rst_dwait", {30'd0, dwait}, 32'd3);
        chk("rst_ramen", {30'd0, ramREN, ramWEN}, 32'd0);
        chk("rst_ccwait", {30'd0, ccwait}, 32'd0);
        tick(); RST = 1'b0;
        // core0 snooped read, other core clean
        cctrans = 2'b01; dREN = 2'b01; daddr0 = 32'h100; ramready = 1'b1;
        neg(); chk("r19_idle_dwait", {30'd0, dwait}, 32'd3);
        tick(); cctrans = 2'b00;
        neg(); chk("r19_ccwait", {30'd0, ccwait}, 32'd2);
        chk("r19_snoopaddr1", ccsnoopaddr1, 32'h100);
        chk("r19_ccinv", {30'd0, ccinv}, 32'd0);
        tick(); neg(); chk("r19_w0_dwait0", {31'd0, dwait[0]}, 32'd0);
        chk("r19_w0_ren", {31'd0, ramREN}, 32'd1);
        chk("r19_w0_addr", ramaddr, 32'h100);
        tick(); neg(); chk("r19_w1_dwait0", {31'd0, dwait[0]}, 32'd0);
        tick(); dREN = 2'b00;
        neg(); chk("r19_idle_ccwait", {30'd0, ccwait}, 32'd0);
        chk("r19_idle_ren", {31'd0, ramREN}, 32'd0);
        // core1 write-intent snoop hits modified line in core0
        tick(); cctrans = 2'b10; ccwrite = 2'b11; daddr1 = 32'h200; daddr0 = 32'h300; dstore0 = 32'hDEADBEEF;
        neg();
        tick(); cctrans = 2'b00;
        neg(); chk("r20_ccinv", {30'd0, ccinv}, 32'd1);
        chk("r20_ccwait", {30'd0, ccwait}, 32'd1);
        chk("r20_snoopaddr0", ccsnoopaddr0, 32'h200);
        for (int w = 0; w < 2; w++) begin
            tick(); neg();
            chk("r20_wen", {31'd0, ramWEN}, 32'd1);
            chk("r20_ramstore", ramstore, 32'hDEADBEEF);
            chk("r20_dload1", dload1, 32'hDEADBEEF);
            chk("r20_dwait", {30'd0, dwait}, 32'd0);
            chk("r20_ramaddr", ramaddr, 32'h300);
        end
        tick(); ccwrite = 2'b00;
        neg(); chk("r20_idle_wen", {31'd0, ramWEN}, 32'd0);
        chk("r20_idle_ccinv", {30'd0, ccinv}, 32'd0);
        // simultaneous snoops after reset: core0 first, then core1
        tick(); RST = 1'b1;
        tick(); RST = 1'b0;
        cctrans = 2'b11; dREN = 2'b11; daddr0 = 32'h500; daddr1 = 32'h600;
        neg();
        tick(); cctrans = 2'b10;
        neg(); chk("r21_first_ccwait", {30'd0, ccwait}, 32'd2);
        chk("r21_first_saddr", ccsnoopaddr1, 32'h500);
        tick(); neg(); chk("r21_first_dwait", {30'd0, dwait}, 32'd2);
        chk("r21_first_addr", ramaddr, 32'h500);
        tick(); neg(); chk("r21_first_dwait2", {30'd0, dwait}, 32'd2);
        tick(); dREN = 2'b10;
        neg(); chk("r21_gap_dwait", {30'd0, dwait}, 32'd3);
        tick(); cctrans = 2'b00;
        neg(); chk("r21_second_ccwait", {30'd0, ccwait}, 32'd1);
        chk("r21_second_saddr", ccsnoopaddr0, 32'h600);
        tick(); neg(); chk("r21_second_dwait", {30'd0, dwait}, 32'd1);
        chk("r21_second_addr", ramaddr, 32'h600);
        tick(); tick(); dREN = 2'b00;
        neg(); chk("r21_end_ccwait", {30'd0, ccwait}, 32'd0);
        // slow-memory eviction from core0
        tick(); dWEN = 2'b01; daddr0 = 32'h40; dstore0 = 32'h1234; ramready = 1'b0;
        neg();
        comp = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            ramready = (k == 3 || k == 7);
            dWEN = (k < 8) ? 2'b01 : 2'b00;
            neg();
            if (ramWEN && ramready) comp++;
            if (k < 8) begin
                chk("r22_dwait0", {31'd0, dwait[0]}, {31'd0, !ramready});
                chk("r22_addr", ramaddr, 32'h40);
            end else begin
                chk("r22_idle_wen", {31'd0, ramWEN}, 32'd0);
                chk("r22_idle_dwait", {30'd0, dwait}, 32'd3);
            end
        end
        chk("r22_words", comp, 32'd2);
        // reset during second word of a plain read
        tick(); dREN = 2'b01; daddr0 = 32'h700; ramready = 1'b1;
        neg();
        tick(); neg(); chk("r23_w0_ren", {31'd0, ramREN}, 32'd1);
        tick(); ramready = 1'b0;
        neg(); chk("r23_w1_ren", {31'd0, ramREN}, 32'd1);
        #1 RST = 1'b1;
        #1 chk("r23_rst_ren", {31'd0, ramREN}, 32'd0);
        chk("r23_rst_dwait", {30'd0, dwait}, 32'd3);
        chk("r23_rst_ccwait", {30'd0, ccwait}, 32'd0);
        tick(); dREN = 2'b00;
        tick(); RST = 1'b0;
        // core1 read held off across core0's cache-to-cache transfer
        cctrans = 2'b01; ccwrite = 2'b10; dREN = 2'b10; daddr0 = 32'h800; daddr1 = 32'h900; dstore1 = 32'hCAFEF00D;
        neg();
        tick(); cctrans = 2'b00;
        neg(); chk("r24_snoop_dwait", {30'd0, dwait}, 32'd3);
        chk("r24_snoop_ccwait", {30'd0, ccwait}, 32'd2);
        chk("r24_snoop_ccinv", {30'd0, ccinv}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick(); ramready = k[0];
            neg();
            chk("r24_c2c_dwait", {30'd0, dwait}, k[0] ? 32'd0 : 32'd3);
            chk("r24_c2c_wen", {31'd0, ramWEN}, 32'd1);
            chk("r24_c2c_addr", ramaddr, 32'h900);
            chk("r24_c2c_dload0", dload0, 32'hCAFEF00D);
        end
        tick(); ccwrite = 2'b00;
        neg(); chk("r24_idle_dwait", {30'd0, dwait}, 32'd3);
        chk("r24_idle_wen", {31'd0, ramWEN}, 32'd0);
        tick(); neg(); chk("r24_rd_dwait", {30'd0, dwait}, 32'd1);
        chk("r24_rd_ren", {31'd0, ramREN}, 32'd1);
        chk("r24_rd_addr", ramaddr, 32'h900);
        tick(); tick(); dREN = 2'b00;
        neg(); chk("r24_end_dwait", {30'd0, dwait}, 32'd3);
        // randomized traffic with occasional asynchronous reset
        for (int c = 0; c < 3000; c++) begin
            tick();
            RST = ($urandom_range(0, 199) == 0);
            cctrans = rb(20); ccwrite = rb(50); dREN = rb(35); dWEN = rb(25);
            daddr0 = $urandom; daddr1 = $urandom; dstore0 = $urandom; dstore1 = $urandom;
            ramload = $urandom; ramready = ($urandom_range(0, 99) < 55);
        end
        tick();
        RST = 1'b0; cctrans = '0; dREN = '0; dWEN = '0; ramready = 1'b1;
        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
